// File: rtl/uart_tx_queue.sv
// Byte FIFO plus transmit sequencer feeding the UART transmitter one frame at a time.
// Define UART_TXQ_STATS_EN to add saturating drop_count / retry_count outputs.
module uart_tx_queue #(
   parameter int DEPTH_LOG2   = 4,
   parameter int WAIT_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [7:0]            tx_data,
   output logic                  tx_ena,
   input  logic                  tx_sending,
   input  logic                  tx_sent,
`ifdef UART_TXQ_STATS_EN
   output logic [15:0]           drop_count,
   output logic [7:0]            retry_count,
`endif
   output logic                  idle
);
   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [7:0]          TMO_LAST   = 8'(WAIT_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state, state_nxt;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
   logic [7:0]            tmo_cnt;
   logic                  sending_q, sent_q;
   logic                  pop, push, drop, tmo_hit, done_edge, cnt_clr, cnt_inc;

   assign full      = (level == LEVEL_FULL);
   assign empty     = (level == '0);
   assign pop       = (state == LOAD) && !empty;
   // A pop in the same cycle frees a slot, so a write while full still lands.
   assign push      = wr_en && (!full || pop);
   assign drop      = wr_en && full && !pop;
   assign done_edge = (!sent_q && tx_sent) || (sending_q && !tx_sending);
   assign tmo_hit   = (state == WAIT_BUSY) && !tx_sending && (tmo_cnt == TMO_LAST);
   assign idle      = (state == IDLE) && empty;

   always_comb begin
      state_nxt = state;
      tx_ena    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      unique case (state)
         IDLE:      if (!empty) state_nxt = LOAD;
         LOAD:      state_nxt = START;
         START: begin
            tx_ena    = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_sending)   state_nxt = WAIT_DONE;
            else if (tmo_hit) state_nxt = START;
            else              cnt_inc   = 1'b1;
         end
         WAIT_DONE: if (done_edge) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         tx_data   <= 8'h00;
         tmo_cnt   <= 8'h00;
         sending_q <= 1'b0;
         sent_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         overflow  <= drop;
         sending_q <= tx_sending;
         sent_q    <= tx_sent;
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
            tx_data <= mem[rd_ptr];
         end
         if (push && !pop)      level <= level + (DEPTH_LOG2+1)'(1);
         else if (pop && !push) level <= level - (DEPTH_LOG2+1)'(1);
         if (cnt_clr)      tmo_cnt <= 8'h00;
         else if (cnt_inc) tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

`ifdef UART_TXQ_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count  <= 16'h0000;
         retry_count <= 8'h00;
      end else begin
         if (drop)    drop_count  <= sat_inc16(drop_count);
         if (tmo_hit) retry_count <= sat_inc8(retry_count);
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: transmitter model, byte scoreboard and directed/random phases.
module tb_uart_tx_queue;
   localparam int DL    = 4;
   localparam int DEPTH = 1 << DL;
   localparam int WT    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_en = 1'b0;
   logic        full, empty, overflow, tx_ena, idle;
   logic [DL:0] level;
   logic [7:0]  tx_data;
   logic        tx_sending, tx_sent;
`ifdef UART_TXQ_STATS_EN
   logic [15:0] drop_count;
   logic [7:0]  retry_count;
`endif

   uart_tx_queue #(.DEPTH_LOG2(DL), .WAIT_TIMEOUT(WT)) dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
      .full(full), .empty(empty), .level(level), .overflow(overflow),
      .tx_data(tx_data), .tx_ena(tx_ena), .tx_sending(tx_sending), .tx_sent(tx_sent),
`ifdef UART_TXQ_STATS_EN
      .drop_count(drop_count), .retry_count(retry_count),
`endif
      .idle(idle)
   );

   int         tests = 0, fails = 0, cyc = 0;
   int         ena_count = 0, n_retry = 0, last_ena_cyc = 0, frame_len = 160;
   int         tx_rise, tx_flen, tx_mode;
   bit         mute = 0, rand_tx = 0, pending = 0;
   logic [7:0] last_byte = 8'h00, mon_e;
   logic [7:0] exp_q[$];

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transmitter model: busy some cycles after tx_ena, then signals completion.
   initial begin
      tx_sending = 1'b0;
      tx_sent    = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (tx_ena === 1'b1 && !mute && !reset) begin
            if (rand_tx) begin
               tx_rise = $urandom_range(3, 1);
               tx_flen = $urandom_range(12, 2);
               tx_mode = $urandom_range(2, 0);
            end else begin
               tx_rise = 2;
               tx_flen = frame_len;
               tx_mode = 0;
            end
            repeat (tx_rise) @(posedge clk);
            #1 tx_sending = 1'b1;
            repeat (tx_flen) @(posedge clk);
            #1;
            case (tx_mode)
               0: begin tx_sending = 1'b0; tx_sent = 1'b1; end
               1: begin tx_sent = 1'b1; @(posedge clk); #1 tx_sending = 1'b0; end
               default: begin tx_sending = 1'b0; @(posedge clk); #1 tx_sent = 1'b1; end
            endcase
            @(posedge clk); #1 tx_sent = 1'b0;
         end
      end
   end

   // Monitor: each fresh tx_ena must carry the oldest accepted byte; a reissue repeats it.
   always @(negedge clk) begin
      if (reset) begin
         pending = 0;
      end else begin
         if (tx_sending) pending = 0;
         if (tx_ena === 1'b1) begin
            check("ena_while_tx_busy", tx_sending, 1'b0);
            if (pending) begin
               n_retry++;
               check("reissue_data", tx_data, last_byte);
               check("reissue_gap", cyc - last_ena_cyc, WT + 1);
            end else begin
               check("ena_has_expected_byte", int'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  check("tx_data_order", tx_data, mon_e);
                  last_byte = mon_e;
               end
            end
            pending      = 1;
            last_ena_cyc = cyc;
            ena_count++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input bit accept);
      wr_en   = 1'b1;
      wr_data = d;
      if (accept) exp_q.push_back(d);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic wait_quiet(input int limit, input string name);
      int n = 0;
      do begin @(negedge clk); #1; n++; end
      while (!(idle && !tx_sending && !tx_sent) && n < limit);
      check(name, idle && !tx_sending && !tx_sent, 1'b1);
   endtask

   task automatic wait_ena(input int target, input int limit, input string name);
      int n = 0;
      while (ena_count < target && n < limit) begin @(negedge clk); #1; n++; end
      check(name, int'(ena_count >= target), 1);
   endtask

   task automatic wait_send(input logic v, input int limit, input string name);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (tx_sending !== v && n < limit);
      check(name, tx_sending, v);
   endtask

   initial begin
      int wcyc, base;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_level", level, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_tx_ena", tx_ena, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_idle", idle, 1);
`ifdef UART_TXQ_STATS_EN
      check("rst_drop_count", drop_count, 0);
      check("rst_retry_count", retry_count, 0);
`endif

      // Single byte, long frame: latency and completion.
      tick(1);
      wcyc = cyc;
      wr(8'h41, 1);
      wait_quiet(400, "single_done");
      check("single_latency", last_ena_cyc - wcyc, 3);
      check("single_ena_count", ena_count, 1);
      check("single_tx_data_hold", tx_data, 8'h41);
      check("single_idle", idle, 1);

      // Burst of 16 while the first byte is in flight, then fill and overflow.
      frame_len = 200;
      tick(1);
      for (int i = 0; i < 16; i++) wr(8'(i), 1);
      @(negedge clk);
      check("burst16_level", level, 15);
      check("burst16_full", full, 0);
      check("burst16_no_ovf", overflow, 0);
      tick(1);
      wr(8'h10, 1);
      @(negedge clk);
      check("burst17_level", level, 16);
      check("burst17_full", full, 1);
      tick(1);
      wr(8'hAA, 0);
      @(negedge clk);
      check("ovf_pulse", overflow, 1);
      check("ovf_level", level, 16);
`ifdef UART_TXQ_STATS_EN
      check("ovf_drop_count", drop_count, 1);
`endif
      @(negedge clk);
      check("ovf_one_cycle", overflow, 0);

      // Write in the LOAD cycle while full: accepted, queued last.
      wait_send(1'b0, 400, "burst_first_done");
      frame_len = 5;
      tick(1);
      tick(1);
      wr(8'h55, 1);
      @(negedge clk);
      check("load_push_no_ovf", overflow, 0);
      check("load_push_level", level, 16);
      check("load_push_full", full, 1);
      check("load_push_start", tx_ena, 1);
      tick(1);
      wait_quiet(2000, "burst_drain_done");
      check("burst_drain_all_sent", exp_q.size(), 0);

      // Transmitter silent: byte is reissued until it answers.
      mute = 1;
      tick(1);
      base = ena_count;
      wr(8'h77, 1);
      wait_ena(base + 2, 100, "mute_first_retry");
      tick(1);
      wr(8'h88, 1);
      wait_ena(base + 4, 100, "mute_more_retries");
      check("mute_level_held", level, 1);
      check("mute_not_empty", empty, 0);
      check("mute_tx_data", tx_data, 8'h77);
`ifdef UART_TXQ_STATS_EN
      check("mute_retry_count", retry_count, n_retry);
`endif
      tick(1);
      mute = 0;
      wait_quiet(500, "mute_recover_done");
      check("mute_all_sent", exp_q.size(), 0);

      // Reset while waiting for completion with five bytes queued.
      frame_len = 100;
      tick(1);
      for (int i = 0; i < 6; i++) wr(8'hA0 + 8'(i), 1);
      wait_send(1'b1, 50, "rst_mid_sending");
      tick(3);
      @(negedge clk);
      check("rst_mid_level_before", level, 5);
      tick(1);
      reset = 1'b1;
      exp_q.delete();
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_level", level, 0);
      check("rst_mid_empty", empty, 1);
      check("rst_mid_tx_ena", tx_ena, 0);
      check("rst_mid_idle", idle, 1);
`ifdef UART_TXQ_STATS_EN
      check("rst_mid_drop_count", drop_count, 0);
      check("rst_mid_retry_count", retry_count, 0);
`endif
      base = ena_count;
      wait_quiet(300, "rst_mid_tx_finishes");
      tick(6);
      @(negedge clk);
      check("rst_mid_no_late_ena", ena_count, base);
      check("rst_mid_still_idle", idle, 1);

      // Random traffic against random transmitter timing.
      rand_tx = 1;
      tick(1);
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(1, 0) == 0 && exp_q.size() < DEPTH) wr(8'($urandom), 1);
         else tick(1);
      end
      wait_quiet(4000, "random_drain_done");
      check("random_all_sent", exp_q.size(), 0);
      check("random_no_ovf", overflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
